// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   rx_state_t      : receiver FSM states
//   UART_BAUD_DIV   : clk cycles per bit (50 MHz / 19200 baud)
//   UART_FRAME_BITS : samples per 8N1 frame (start + 8 data + stop)
package uart_pkg;

    typedef enum logic {IDLE, RECEIVE} rx_state_t;

    localparam int UART_BAUD_DIV   = 2604;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_rx_cmd_if.sv
// uart_rx_cmd_if: byte handshake between the UART receiver and its consumer.
//   rx_data   : last received byte, stable while rdy is high
//   rdy       : rx_data holds an unacknowledged byte
//   frame_err : bad stop bit seen on the byte in rx_data
//   clr_rdy   : one-cycle acknowledge from the consumer
// master = receiver side, slave = consumer side.
interface uart_rx_cmd_if;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frame_err;
    logic       clr_rdy;

    modport master (output rx_data, rdy, frame_err, input clr_rdy);
    modport slave  (input rx_data, rdy, frame_err, output clr_rdy);
endinterface

// File: rtl/uart_rx_synch.sv
// uart_rx_synch: two-flop synchronizer for the asynchronous RX pin plus a
// falling-edge detect on the synchronized line.
//   clk, rst : system clock, synchronous active-high reset
//   rx_async : raw serial input
//   rx_s     : synchronized RX (second flop)
//   fall     : rx_s went 1 -> 0 this cycle
// All flops preset high on reset so an idle-high line never looks like a
// start edge right after reset.
module uart_rx_synch (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic rx_s,
    output logic fall
);
    logic rx_ff1;
    logic rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ff1  <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_ff1  <= rx_async;
            rx_s    <= rx_ff1;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;
endmodule

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver for the BLE command line.
//   clk, rst : system clock, synchronous active-high reset
//   RX       : asynchronous serial line, idles high
//   bus      : uart_rx_cmd_if.master (rx_data, rdy, frame_err out; clr_rdy in)
// Parameter BAUD_DIV: clk cycles per bit.
// Optional macro UART_RX_FRAME_ERR_EN: rejects false starts (start bit high
// at its mid-bit sample) and flags a low stop bit on frame_err. Without it
// frame_err stays 0 and every detected start yields a byte.
module uart_rx_cmd
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX,
    uart_rx_cmd_if.master      bus
);
    localparam logic [11:0] BAUD_FULL = 12'(BAUD_DIV);
    localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);
    localparam logic [3:0]  LAST_BIT  = 4'(UART_FRAME_BITS - 1);

    logic rx_s;
    logic fall;

    uart_rx_synch u_synch (
        .clk      (clk),
        .rst      (rst),
        .rx_async (RX),
        .rx_s     (rx_s),
        .fall     (fall)
    );

    rx_state_t   state_q, state_d;
    logic [11:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [9:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        ferr_q, ferr_d;

    logic false_start;
    logic stop_err;

`ifdef UART_RX_FRAME_ERR_EN
    assign false_start = (bit_q == 4'd0) && rx_s;
    assign stop_err    = ~rx_s;
`else
    assign false_start = 1'b0;
    assign stop_err    = 1'b0;
`endif

    // The start bit ends up in shift_q[0] and is never consumed.
    logic unused_start;
    assign unused_start = shift_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        ferr_d  = ferr_q;

        if (bus.clr_rdy) begin
            rdy_d  = 1'b0;
            ferr_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = RECEIVE;
                    baud_d  = BAUD_HALF;   // first sample lands mid start bit
                    bit_d   = '0;
                    rdy_d   = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            RECEIVE: begin
                // Count reaches zero on this edge: sample and reload.
                if (baud_q == 12'd1) begin
                    baud_d = BAUD_FULL;
                    if (false_start) begin
                        state_d = IDLE;
                    end else begin
                        shift_d = {rx_s, shift_q[9:1]};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == LAST_BIT) begin
                            // Stop sample: publish the byte. Placed after the
                            // clr_rdy clear so a coincident set wins.
                            state_d = IDLE;
                            data_d  = shift_d[8:1];
                            rdy_d   = 1'b1;
                            ferr_d  = stop_err;
                        end
                    end
                end else begin
                    baud_d = baud_q - 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = ferr_q;
endmodule
